clk_monitor: RTL and testbench



---
 rtl/clk_monitor.sv | 168 ++++++++++++++++
 tb/tb_clk_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// Health monitor for a divided clock: measures each half-period in clk cycles and tracks lock/fault.
// Build option CLK_MONITOR_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detector.
module clk_monitor #(
    parameter int CW       = 16,
    parameter int EXP_HALF = 5,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_in,
    output logic          rise_pulse,
    output logic          fall_pulse,
    output logic [CW-1:0] half_period,
    output logic          locked,
    output logic          fault,
    output logic          err_pulse,
    output logic [7:0]    err_count,
    output logic [1:0]    state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACQ   = 2'd1,
        LOCK  = 2'd2,
        FAULT = 2'd3
    } state_t;

    // Acceptance window in CW+1 bits so EXP_HALF+TOL never wraps.
    localparam int          LO_I   = (EXP_HALF > TOL) ? (EXP_HALF - TOL) : 0;
    localparam int          HI_I   = EXP_HALF + TOL;
    localparam logic [CW:0] LO     = LO_I[CW:0];
    localparam logic [CW:0] HI     = HI_I[CW:0];
    localparam logic [7:0]  LOCK_W = LOCK_CNT[7:0];

    logic          s_in;
    logic          s_reg;
    logic          s_d_reg;
    logic [CW-1:0] hp_cnt_reg;
    logic [CW-1:0] hp_inc;
    logic [7:0]    good_reg;
    logic [7:0]    good_next;
    logic [7:0]    good_inc;
    state_t        state_reg;
    state_t        state_next;
    logic          err_next;
    logic          edge_det;
    logic          rise_det;
    logic          fall_det;
    logic          meas_good;
    logic          timeout;

`ifdef CLK_MONITOR_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], clk_in};
        end
    end

    assign s_in = sync_reg[1];
`else
    assign s_in = clk_in;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_reg   <= 1'b0;
            s_d_reg <= 1'b0;
        end else begin
            s_reg   <= s_in;
            s_d_reg <= s_reg;
        end
    end

    assign edge_det  = s_reg ^ s_d_reg;
    assign rise_det  = s_reg & ~s_d_reg;
    assign fall_det  = ~s_reg & s_d_reg;
    assign hp_inc    = (hp_cnt_reg == {CW{1'b1}}) ? hp_cnt_reg : hp_cnt_reg + 1'b1;
    assign meas_good = ({1'b0, hp_inc} >= LO) && ({1'b0, hp_inc} <= HI);
    // hp_cnt crosses HI exactly once per gap, so this fires at most once.
    assign timeout   = !edge_det && ({1'b0, hp_cnt_reg} == HI);
    assign good_inc  = good_reg + 8'd1;

    always_comb begin
        state_next = state_reg;
        good_next  = good_reg;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                // First edge closes a partial period; it is not judged.
                if (edge_det) begin
                    state_next = ACQ;
                    good_next  = 8'd0;
                end
            end
            ACQ: begin
                if (edge_det) begin
                    if (meas_good) begin
                        good_next = good_inc;
                        if (good_inc >= LOCK_W) begin
                            state_next = LOCK;
                        end
                    end else begin
                        good_next = 8'd0;
                        err_next  = 1'b1;
                    end
                end else if (timeout) begin
                    good_next = 8'd0;
                    err_next  = 1'b1;
                end
            end
            LOCK: begin
                if ((edge_det && !meas_good) || timeout) begin
                    state_next = FAULT;
                    err_next   = 1'b1;
                end
            end
            FAULT: begin
                if (edge_det && meas_good) begin
                    state_next = ACQ;
                    good_next  = 8'd1;
                end else if (edge_det || timeout) begin
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                good_next  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            good_reg    <= 8'd0;
            hp_cnt_reg  <= '0;
            half_period <= '0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state_reg  <= state_next;
            good_reg   <= good_next;
            rise_pulse <= rise_det;
            fall_pulse <= fall_det;
            err_pulse  <= err_next;
            if (err_next && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (edge_det) begin
                half_period <= hp_inc;
                hp_cnt_reg  <= '0;
            end else begin
                hp_cnt_reg  <= hp_inc;
            end
        end
    end

    assign state  = state_reg;
    assign locked = (state_reg == LOCK);
    assign fault  = (state_reg == FAULT);

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench: three monitors (5/0, 5/1, 1/0) watch one shared divided-clock stimulus.
// Expected edge/timeout events are queued when the stimulus is scheduled and popped on DUT pulses.
module tb_clk_monitor;
`ifdef CLK_MONITOR_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif
    localparam int NI = 3;

    typedef struct {
        int cyc;
        bit rise;
        bit fall;
        int hp;
        int st;
        bit err;
        int ec;
    } ev_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic clk_in = 1'b0;
    logic [NI-1:0] rise_p, fall_p, err_p, lock_p, fault_p;
    logic [15:0]   hp_p [NI];
    logic [7:0]    ec_p [NI];
    logic [1:0]    st_p [NI];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int last_tog = 0;
    int m_st [NI];
    int m_g  [NI];
    int m_ec [NI];
    int m_hp [NI];
    ev_t q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pexp(input int i);
        return (i == 2) ? 1 : 5;
    endfunction

    function automatic int ptol(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            clk_monitor #(
                .CW(16), .EXP_HALF(pexp(gi)), .TOL(ptol(gi)), .LOCK_CNT(4)
            ) dut (
                .clk(clk), .reset(reset), .clk_in(clk_in),
                .rise_pulse(rise_p[gi]), .fall_pulse(fall_p[gi]),
                .half_period(hp_p[gi]), .locked(lock_p[gi]), .fault(fault_p[gi]),
                .err_pulse(err_p[gi]), .err_count(ec_p[gi]), .state(st_p[gi])
            );
            always @(negedge clk) judge(gi);
        end
    endgenerate

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input int i, input ev_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_ev(input int i, output ev_t e, output bit ok);
        ok = 1'b0;
        e  = '{default: 0};
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
        endcase
    endtask

    task automatic judge(input int i);
        ev_t e;
        bit  ok;
        if (rise_p[i] || fall_p[i] || err_p[i]) begin
            pop_ev(i, e, ok);
            if (!ok) begin
                check_val($sformatf("u%0d_unexpected_event", i), 1, 0);
            end else begin
                check_val($sformatf("u%0d_cycle", i), cyc, e.cyc);
                check_val($sformatf("u%0d_rise", i), int'(rise_p[i]), int'(e.rise));
                check_val($sformatf("u%0d_fall", i), int'(fall_p[i]), int'(e.fall));
                check_val($sformatf("u%0d_err", i), int'(err_p[i]), int'(e.err));
                if (e.hp >= 0) check_val($sformatf("u%0d_half_period", i), int'(hp_p[i]), e.hp);
                check_val($sformatf("u%0d_state", i), int'(st_p[i]), e.st);
                check_val($sformatf("u%0d_locked", i), int'(lock_p[i]), int'(e.st == 2));
                check_val($sformatf("u%0d_fault", i), int'(fault_p[i]), int'(e.st == 3));
                check_val($sformatf("u%0d_err_count", i), int'(ec_p[i]), e.ec);
                $display("u%0d event @%0d: rise=%0d fall=%0d err=%0d hp=%0d state=%0d ecnt=%0d",
                         i, cyc, rise_p[i], fall_p[i], err_p[i], hp_p[i], st_p[i], ec_p[i]);
            end
        end
    endtask

    task automatic model_edge(input int i, input int meas, input int at, input bit lvl);
        ev_t e;
        bit  good;
        bit  err = 1'b0;
        good = (meas + ptol(i) >= pexp(i)) && (meas <= pexp(i) + ptol(i));
        case (m_st[i])
            0: begin m_st[i] = 1; m_g[i] = 0; m_hp[i] = -1; end
            1: begin
                m_hp[i] = meas;
                if (good) begin
                    m_g[i]++;
                    if (m_g[i] >= 4) m_st[i] = 2;
                end else begin
                    m_g[i] = 0;
                    err = 1'b1;
                end
            end
            2: begin
                m_hp[i] = meas;
                if (!good) begin m_st[i] = 3; err = 1'b1; end
            end
            default: begin
                m_hp[i] = meas;
                if (good) begin m_st[i] = 1; m_g[i] = 1; end
                else err = 1'b1;
            end
        endcase
        if (err && m_ec[i] < 255) m_ec[i]++;
        e.cyc = at; e.rise = lvl; e.fall = !lvl; e.hp = m_hp[i];
        e.st = m_st[i]; e.err = err; e.ec = m_ec[i];
        push_ev(i, e);
    endtask

    task automatic model_timeout(input int i, input int at);
        ev_t e;
        if (m_st[i] == 0) return;
        if (m_st[i] == 1) m_g[i] = 0;
        if (m_st[i] == 2) m_st[i] = 3;
        if (m_ec[i] < 255) m_ec[i]++;
        e.cyc = at; e.rise = 1'b0; e.fall = 1'b0; e.hp = m_hp[i];
        e.st = m_st[i]; e.err = 1'b1; e.ec = m_ec[i];
        push_ev(i, e);
    endtask

    // Wait g cycles, optionally toggling clk_in at the end; expectations are queued up front.
    task automatic step(input int g, input bit tog);
        int x, d0, d1;
        for (int i = 0; i < NI; i++) begin
            x  = pexp(i) + ptol(i);
            d0 = cyc - last_tog;
            d1 = cyc + g - last_tog;
            if (d0 < x + 1 && d1 >= x + 1 && !(tog && d1 == x + 1))
                model_timeout(i, last_tog + x + 1 + LAT);
            if (tog) model_edge(i, d1, cyc + g + LAT, !clk_in);
        end
        for (int k = 0; k < g; k++) begin
            @(posedge clk);
            #1;
        end
        if (tog) begin
            clk_in   = !clk_in;
            last_tog = cyc;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        clk_in = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d_rst_rise", i), int'(rise_p[i]), 0);
            check_val($sformatf("u%0d_rst_fall", i), int'(fall_p[i]), 0);
            check_val($sformatf("u%0d_rst_hp", i), int'(hp_p[i]), 0);
            check_val($sformatf("u%0d_rst_locked", i), int'(lock_p[i]), 0);
            check_val($sformatf("u%0d_rst_fault", i), int'(fault_p[i]), 0);
            check_val($sformatf("u%0d_rst_err", i), int'(err_p[i]), 0);
            check_val($sformatf("u%0d_rst_ecnt", i), int'(ec_p[i]), 0);
            check_val($sformatf("u%0d_rst_state", i), int'(st_p[i]), 0);
            m_st[i] = 0; m_g[i] = 0; m_ec[i] = 0; m_hp[i] = -1;
        end
        $display("reset applied @%0d", cyc);
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        last_tog = cyc;
    endtask

    initial begin
        do_reset();
        // Acquire and lock at a 5-cycle half-period.
        step(3, 1'b1);
        repeat (8) step(5, 1'b1);
        // Stall the clock: one timeout per monitor, then silence.
        step(20, 1'b0);
        // Resume: first edge is a long gap, then reacquire.
        repeat (7) step(5, 1'b1);
        // One short half-period; only the TOL=1 monitor tolerates it.
        step(4, 1'b1);
        repeat (2) step(5, 1'b1);
        // Fast toggling that the EXP_HALF=1 monitor locks onto.
        repeat (12) step(1, 1'b1);
        step(16, 1'b0);
        // Reset mid-ACQ.
        do_reset();
        step(3, 1'b1);
        repeat (2) step(5, 1'b1);
        do_reset();
        // Reset mid-LOCK.
        step(2, 1'b1);
        repeat (6) step(5, 1'b1);
        do_reset();
        // Flood with bad edges to saturate err_count.
        step(3, 1'b1);
        repeat (300) step(2, 1'b1);
        step(16, 1'b0);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d_ecnt_saturated", i), int'(ec_p[i]), 255);
        end
        check_val("u0_pending", q0.size(), 0);
        check_val("u1_pending", q1.size(), 0);
        check_val("u2_pending", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
